// File: rtl/image_line_feeder.sv
// -----------------------------------------------------------------------------
// image_line_feeder
//
// Streams an 8-bit greyscale frame from a synchronous frame memory into the
// 4-line-buffer window generator, one line at a time. The first PRIME_LINES
// lines are sent back to back. After that, each further line needs one
// credit, and a credit is returned by an i_interrupt pulse from the window
// generator ("one line consumed, one buffer free"). A line buffer therefore
// never receives new pixels while it still holds an unread line.
//
// Ports
//   clk                 system clock, all logic on the rising edge
//   reset               synchronous, active-low reset
//   i_start             single-cycle frame start request (ignored while busy)
//   o_mem_addr          frame memory read address
//   o_mem_rd            frame memory read enable (data returns 1 cycle later)
//   i_mem_data          frame memory read data
//   o_pixel_data        pixel to the window generator
//   o_pixel_data_valid  pixel strobe (o_mem_rd delayed by one cycle)
//   i_interrupt         one line consumed by the window generator
//   o_busy              frame in progress (SEND, WAIT, FLUSH)
//   o_done              one-cycle pulse after the last pixel of the frame
//   o_lines_sent        lines fully issued in the current frame
// -----------------------------------------------------------------------------
module image_line_feeder #(
  parameter int LINE_WIDTH  = 512,  // pixels per line, equals line buffer depth
  parameter int NUM_LINES   = 512,  // lines per frame
  parameter int PRIME_LINES = 4,    // lines sent before the first interrupt
  parameter int ADDR_W      = 18    // 2**ADDR_W >= LINE_WIDTH*NUM_LINES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_pixel_data,
  output logic              o_pixel_data_valid,
  input  logic              i_interrupt,
  output logic              o_busy,
  output logic              o_done,
  output logic [9:0]        o_lines_sent
);

  localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(LINE_WIDTH - 1);
  localparam logic [9:0]       LINES_TOTAL  = 10'(NUM_LINES);
  localparam logic [2:0]       CREDITS_FULL = 3'(PRIME_LINES);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [COL_W-1:0] col;
  logic [9:0]       lines;
  logic [9:0]       lines_inc;
  logic [2:0]       credits;
  logic [2:0]       credits_next;
  logic [7:0]       pixel_hold;
  logic             line_end;
  logic             frame_end;

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  assign o_mem_rd     = (state == S_SEND);
  assign o_busy       = (state != S_IDLE);
  assign o_lines_sent = lines;

  // The memory's registered read data arrives in the same cycle as the
  // delayed strobe, so it is passed straight through while valid. Between
  // pixels the last delivered value is held so the bus does not wander.
  assign o_pixel_data = o_pixel_data_valid ? i_mem_data : pixel_hold;

  // Last read of a line, and last read of the whole frame.
  assign line_end  = o_mem_rd && (col == COL_LAST);
  assign lines_inc = lines + 10'd1;
  assign frame_end = line_end && (lines_inc == LINES_TOTAL);

  // ---------------------------------------------------------------------------
  // Credit accounting
  //   A credit is a free line buffer. Issuing the last read of a line spends
  //   one; an interrupt returns one. When both happen on the same edge they
  //   cancel. Surplus interrupts beyond PRIME_LINES are dropped, and
  //   interrupts while idle mean nothing for the next frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    credits_next = credits;
    if (state == S_IDLE) begin
      if (i_start) begin
        credits_next = CREDITS_FULL;
      end
    end else if (line_end) begin
      if (!i_interrupt) begin
        credits_next = credits - 3'd1;
      end
    end else if (i_interrupt && (credits < CREDITS_FULL)) begin
      credits_next = credits + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        // Keep reading without a bubble while a buffer is still free.
        if (frame_end) begin
          state_next = S_FLUSH;
        end else if (line_end && (credits_next == 3'd0)) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_interrupt) begin
          state_next = S_SEND;
        end
      end
      S_FLUSH: begin
        // One cycle for the final pixel to leave; o_done follows it.
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all state is written with non-blocking assignments so every
    // register samples values from before the edge, independent of the
    // order of statements in this block.
    if (!reset) begin
      state              <= S_IDLE;
      o_mem_addr         <= '0;
      col                <= '0;
      lines              <= '0;
      credits            <= CREDITS_FULL;
      o_pixel_data_valid <= 1'b0;
      pixel_hold         <= 8'h00;
      o_done             <= 1'b0;
    end else begin
      state   <= state_next;
      credits <= credits_next;

      // Memory data comes back one cycle after the read, so the strobe is
      // simply the read enable delayed by one cycle.
      o_pixel_data_valid <= o_mem_rd;
      if (o_pixel_data_valid) begin
        pixel_hold <= i_mem_data;
      end

      // FLUSH is the cycle of the final pixel; done pulses right after it.
      o_done <= (state == S_FLUSH);

      if ((state == S_IDLE) && i_start) begin
        o_mem_addr <= '0;
        col        <= '0;
        lines      <= '0;
      end

      if (state == S_SEND) begin
        // At the end of the frame the address returns to 0 explicitly rather
        // than relying on the counter width to wrap.
        o_mem_addr <= frame_end ? '0 : o_mem_addr + 1'b1;
        col        <= line_end ? '0 : col + 1'b1;
        if (line_end) begin
          lines <= lines_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_line_feeder.sv
// -----------------------------------------------------------------------------
// tb_image_line_feeder
//
// Self-checking bench for image_line_feeder on a reduced frame (32x16 pixels,
// 4 priming lines). A frame memory filled with random bytes feeds the DUT.
// A negedge monitor compares the stream against the frame: reads must walk
// the addresses 0,1,2,... of the frame, the k-th valid pixel must equal
// mem[k], the strobe must follow the read enable by one cycle, and, while the
// window-generator model is active, no line may arrive while all line buffers
// still hold unread lines. The window-generator model consumes completed lines
// at random times and answers each with an interrupt pulse.
// -----------------------------------------------------------------------------
module tb_image_line_feeder;

  localparam int LW        = 32;
  localparam int NL        = 16;
  localparam int PL        = 4;
  localparam int AW        = 9;
  localparam int FRAME_PIX = LW * NL;
  localparam int NONE      = 1 << 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd;
  logic [7:0]    i_mem_data = 8'h00;
  logic [7:0]    o_pixel_data;
  logic          o_pixel_data_valid;
  logic          i_interrupt;
  logic          o_busy;
  logic          o_done;
  logic [9:0]    o_lines_sent;

  logic          irq_dir   = 1'b0;
  logic          irq_model = 1'b0;
  logic          model_en  = 1'b0;

  logic [7:0]    mem [FRAME_PIX];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Monitor state (written only by the monitor process).
  int   frame_id = 0;
  int   seen_id  = 0;
  int   exp_addr = 0;
  int   pix_cnt  = 0;
  int   consumed = 0;
  int   cyc      = 0;
  int   last_valid_cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic busy_at_done     = 1'b0;
  logic busy_before_done = 1'b0;
  logic prev_rd   = 1'b0;
  logic prev_busy = 1'b0;
  int   addr_err  = 0;
  int   pix_err   = 0;
  int   valid_err = 0;
  int   ovw_err   = 0;

  always #5 clk = ~clk;

  assign i_interrupt = irq_dir | irq_model;

  image_line_feeder #(
    .LINE_WIDTH (LW),
    .NUM_LINES  (NL),
    .PRIME_LINES(PL),
    .ADDR_W     (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .i_start           (i_start),
    .o_mem_addr        (o_mem_addr),
    .o_mem_rd          (o_mem_rd),
    .i_mem_data        (i_mem_data),
    .o_pixel_data      (o_pixel_data),
    .o_pixel_data_valid(o_pixel_data_valid),
    .i_interrupt       (i_interrupt),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_lines_sent      (o_lines_sent)
  );

  // Synchronous frame memory: data for a read appears one cycle later.
  always @(posedge clk) begin
    if (o_mem_rd) i_mem_data <= mem[o_mem_addr];
  end

  // Stream monitor and window-generator model.
  always @(negedge clk) begin
    if (frame_id != seen_id) begin
      seen_id   <= frame_id;
      exp_addr  <= 0;
      pix_cnt   <= 0;
      consumed  <= 0;
      done_cnt  <= 0;
      irq_model <= 1'b0;
    end else begin
      if (o_mem_rd) begin
        if ((o_mem_addr !== AW'(exp_addr)) || (exp_addr >= FRAME_PIX)) addr_err <= addr_err + 1;
        exp_addr <= exp_addr + 1;
      end
      if (o_pixel_data_valid) begin
        if (o_pixel_data !== mem[pix_cnt % FRAME_PIX]) pix_err <= pix_err + 1;
        if (model_en && (pix_cnt % LW == 0) && ((pix_cnt / LW - consumed) >= PL)) ovw_err <= ovw_err + 1;
        pix_cnt        <= pix_cnt + 1;
        last_valid_cyc <= cyc;
      end
      if (o_done === 1'b1) begin
        done_cnt         <= done_cnt + 1;
        done_cyc         <= cyc;
        busy_at_done     <= o_busy;
        busy_before_done <= prev_busy;
      end
      if (model_en && (pix_cnt / LW > consumed) && ($urandom_range(0, 63) == 0)) begin
        irq_model <= 1'b1;
        consumed  <= consumed + 1;
      end else begin
        irq_model <= 1'b0;
      end
    end
    // The strobe is the read enable one cycle late, unless reset intervened.
    if (o_pixel_data_valid !== (prev_rd & reset)) valid_err <= valid_err + 1;
    prev_rd   <= o_mem_rd;
    prev_busy <= o_busy;
    cyc       <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_addr_errors"}, addr_err, 0);
    check({tag, "_pixel_errors"}, pix_err, 0);
    check({tag, "_valid_errors"}, valid_err, 0);
    check({tag, "_overwrite_errors"}, ovw_err, 0);
  endtask

  // Inputs change 1 time unit after the falling edge, so the monitor has
  // already sampled that edge and the DUT sees them at the next rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic new_frame();
    frame_id++;
    step();
  endtask

  // Counts one contiguous run of reads. Interrupts are raised on the read
  // cycles whose address lies in [irq_lo, irq_hi] at even offsets, and
  // i_start is raised on the read cycle of address start_at.
  task automatic burst(input int irq_lo, input int irq_hi, input int start_at,
                       output int n, output int first);
    int guard;
    int a;
    n     = 0;
    first = -1;
    guard = 0;
    while (!o_mem_rd && guard < 40) begin
      step();
      guard++;
    end
    while (o_mem_rd && n < 4 * FRAME_PIX) begin
      a = int'(o_mem_addr);
      if (n == 0) first = a;
      n++;
      irq_dir = (a >= irq_lo) && (a <= irq_hi) && ((a - irq_lo) % 2 == 0);
      i_start = (a == start_at);
      step();
    end
    irq_dir = 1'b0;
    i_start = 1'b0;
  endtask

  initial begin
    int n;
    int first;
    int guard;

    reset   = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < FRAME_PIX; i++) mem[i] = 8'($urandom);

    // Reset state.
    repeat (3) step();
    check("rst_mem_rd", o_mem_rd, 0);
    check("rst_valid", o_pixel_data_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_pixel", o_pixel_data, 0);
    check("rst_lines_sent", o_lines_sent, 0);
    reset = 1'b1;
    step();

    // Prime: PL lines back to back, then wait for credits.
    new_frame();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    burst(NONE, -1, -1, n, first);
    check("prime_reads", n, PL * LW);
    check("prime_first_addr", first, 0);
    check("prime_lines_sent", o_lines_sent, PL);
    repeat (8) step();
    check("prime_wait_rd", o_mem_rd, 0);
    check("prime_wait_busy", o_busy, 1);
    check_stream("prime");

    // Refill: one interrupt buys exactly one line.
    irq_dir = 1'b1;
    step();
    irq_dir = 1'b0;
    burst(NONE, -1, -1, n, first);
    check("refill_reads", n, LW);
    check("refill_first_addr", first, PL * LW);
    check("refill_lines_sent", o_lines_sent, PL + 1);
    repeat (4) step();
    check("refill_wait_rd", o_mem_rd, 0);

    // Interrupt on the last read of a line: credit kept, next line follows.
    irq_dir = 1'b1;
    step();
    irq_dir = 1'b0;
    burst((PL + 2) * LW - 1, (PL + 2) * LW - 1, -1, n, first);
    check("coincident_reads", n, 2 * LW);
    check("coincident_first_addr", first, (PL + 1) * LW);
    check("coincident_lines_sent", o_lines_sent, PL + 3);
    check_stream("coincident");

    // Reset in the middle of a line abandons the frame.
    irq_dir = 1'b1;
    step();
    irq_dir = 1'b0;
    guard = 0;
    while (!(o_mem_rd && int'(o_mem_addr) == (PL + 3) * LW + 5) && guard < 40) begin
      step();
      guard++;
    end
    check("midline_addr_reached", o_mem_addr, (PL + 3) * LW + 5);
    reset = 1'b0;
    step();
    check("midrst_mem_rd", o_mem_rd, 0);
    check("midrst_valid", o_pixel_data_valid, 0);
    check("midrst_addr", o_mem_addr, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_lines_sent", o_lines_sent, 0);
    reset = 1'b1;
    step();
    check_stream("midrst");

    // Saturation and start-while-busy: three interrupts with all credits
    // held and a second start request change nothing.
    new_frame();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    burst(2, 6, 10, n, first);
    check("sat_reads", n, PL * LW);
    check("sat_first_addr", first, 0);
    check("sat_lines_sent", o_lines_sent, PL);
    repeat (8) step();
    check("sat_wait_rd", o_mem_rd, 0);
    check("sat_wait_busy", o_busy, 1);
    check_stream("sat");
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Full frame with the window-generator model returning credits.
    new_frame();
    model_en = 1'b1;
    i_start  = 1'b1;
    step();
    i_start  = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      step();
      guard++;
    end
    repeat (5) step();
    check("frame_done_pulses", done_cnt, 1);
    check("frame_pixels", pix_cnt, FRAME_PIX);
    check("done_after_last_valid", done_cyc - last_valid_cyc, 1);
    check("busy_at_done", busy_at_done, 0);
    check("busy_before_done", busy_before_done, 1);
    check("frame_lines_sent", o_lines_sent, NL);
    check("frame_end_addr", o_mem_addr, 0);
    check("frame_end_rd", o_mem_rd, 0);
    model_en = 1'b0;
    step();
    check_stream("frame");

    // New start after a completed frame: reads restart at 0, the line count
    // restarts, and an interrupt on the last priming read extends the burst.
    new_frame();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    burst(PL * LW - 1, PL * LW - 1, -1, n, first);
    check("restart_reads", n, (PL + 1) * LW);
    check("restart_first_addr", first, 0);
    check("restart_lines_sent", o_lines_sent, PL + 1);
    step();
    check_stream("restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
